dmem_wait_ctrl: RTL and testbench

- Multi-cycle data-memory controller between the MIPS core's load/store port and a word-addressed data RAM.
- Adds a parameterised wait-state latency, byte-lane write enables and a ready/valid handshake.
- Provides a stall output so the core holds its state until the memory responds.
- Owns the RAM array internally and replaces the zero-latency data memory in the top level.

---
 rtl/dmem_wait_pkg.sv | 21 ++
 rtl/dmem_wait_ctrl_if.sv | 23 ++
 rtl/dmem_ram_bytewe.sv | 35 +++
 rtl/dmem_wait_ctrl.sv | 106 ++++++++++
 tb/tb_dmem_wait_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_wait_pkg.sv
// Shared types and constants for the wait-state data-memory controller.
package dmem_wait_pkg;

  localparam int CNT_W       = 4;   // wait counter width, LATENCY up to 15
  localparam int DEF_DEPTH   = 64;  // words
  localparam int DEF_LATENCY = 2;   // extra wait cycles before commit

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Access faults when the byte address is not word aligned or the word
  // index falls past the end of the array.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// Load/store port between the core (master) and the memory controller (slave).
interface dmem_wait_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/dmem_ram_bytewe.sv
// Single-port word RAM: byte-lane synchronous write, registered read.
// The array is never reset; contents survive controller resets.
module dmem_ram_bytewe
  import dmem_wait_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8,
  parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_we,
  input  logic                              i_re,
  input  logic [NUM_LANES-1:0]              i_be,
  input  logic [AW-1:0]                     i_addr,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  i_wdata,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  o_rdata
);

  logic [NUM_LANES-1:0][LANE_W-1:0] r_mem [DEPTH];
  logic [NUM_LANES-1:0][LANE_W-1:0] r_rdata;

  // Byte-lane write and registered read share the one address port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (i_be[l]) r_mem[i_addr][l] <= i_wdata[l];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Multi-cycle data-memory controller: captures one request, waits LATENCY
// cycles, commits the access to the internal RAM and pulses a response.
module dmem_wait_ctrl
  import dmem_wait_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic             i_clk,
  input  logic             i_reset,
  dmem_wait_ctrl_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_load_ok;   // last commit was a good load: expose RAM data

  logic              w_err;
  logic              w_commit;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [31:0]       w_ram_rdata;

  // Fault and commit qualifiers work only on the captured request copy.
  // Reset blocks the commit so an in-flight store never reaches the RAM.
  assign w_err    = addr_fault(r_addr, DEPTH);
  assign w_commit = (r_state == WAIT) && (r_cnt == '0) && !i_reset;
  assign w_ram_we = w_commit &&  r_we && !w_err;
  assign w_ram_re = w_commit && !r_we && !w_err;

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_load_ok   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_be    <= bus.req_be;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= CNT_W'(LATENCY);
            r_ready <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_load_ok   <= !r_we && !w_err;
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  dmem_ram_bytewe #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_be    (r_be),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Read data is only meaningful after a fault-free load; stores, faults and
  // reset all present zero. Both terms hold between commits.
  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_load_ok ? w_ram_rdata : 32'h0;
  assign bus.stall     = bus.req_valid && !r_rsp_valid;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Self-checking bench: DUT 0 has LATENCY=2, DUT 1 has LATENCY=0, both DEPTH=64.
module tb_dmem_wait_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        vld  [2];
  logic        we   [2];
  logic [3:0]  be   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic        rdy  [2];
  logic        rv   [2];
  logic        er   [2];
  logic        stl  [2];
  logic [31:0] rd   [2];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_wait_ctrl_if ifa ();
  dmem_wait_ctrl_if ifb ();

  assign ifa.req_valid = vld[0];
  assign ifa.req_we    = we[0];
  assign ifa.req_be    = be[0];
  assign ifa.req_addr  = addr[0];
  assign ifa.req_wdata = wd[0];
  assign rdy[0] = ifa.req_ready;
  assign rv[0]  = ifa.rsp_valid;
  assign er[0]  = ifa.rsp_err;
  assign stl[0] = ifa.stall;
  assign rd[0]  = ifa.rsp_rdata;

  assign ifb.req_valid = vld[1];
  assign ifb.req_we    = we[1];
  assign ifb.req_be    = be[1];
  assign ifb.req_addr  = addr[1];
  assign ifb.req_wdata = wd[1];
  assign rdy[1] = ifb.req_ready;
  assign rv[1]  = ifb.rsp_valid;
  assign er[1]  = ifb.rsp_err;
  assign stl[1] = ifb.stall;
  assign rd[1]  = ifb.rsp_rdata;

  dmem_wait_ctrl #(.DEPTH(64), .LATENCY(2)) u_dut_a (
    .i_clk(clk), .i_reset(rst[0]), .bus(ifa));
  dmem_wait_ctrl #(.DEPTH(64), .LATENCY(0)) u_dut_b (
    .i_clk(clk), .i_reset(rst[1]), .bus(ifb));

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  // Drive one request, hold it until the response, return what was seen.
  // lat is the response cycle relative to the accept cycle (-1 on timeout).
  task automatic access(input int s, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output bit err,
                        output int lat, output int bad_hs);
    lat = -1; bad_hs = 0; rdata = 32'h0; err = 1'b0;
    @(negedge clk);
    vld[s] = 1'b1; we[s] = w; be[s] = b; addr[s] = a; wd[s] = d;
    #1;
    if (!rdy[s]) bad_hs++;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (rv[s]) begin
        lat = k; rdata = rd[s]; err = er[s];
        if (stl[s]) bad_hs++;
        break;
      end
      if (!stl[s]) bad_hs++;
      if (k > 0 && rdy[s]) bad_hs++;
    end
    vld[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (rdy[s] !== 1'b1) begin n_bad++; $display("FAIL reset_ready dut%0d got %b want 1", s, rdy[s]); end
      n_cmp++; if (rv[s] !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid dut%0d got %b want 0", s, rv[s]); end
      n_cmp++; if (rd[s] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata dut%0d got %h want 0", s, rd[s]); end
      n_cmp++; if (er[s] !== 1'b0) begin n_bad++; $display("FAIL reset_err dut%0d got %b want 0", s, er[s]); end
      n_cmp++; if (stl[s] !== 1'b0) begin n_bad++; $display("FAIL reset_stall dut%0d got %b want 0", s, stl[s]); end
    end
  endtask

  task automatic test_load_timing();
    logic [31:0] r; bit e; int lat, bh;
    access(0, 1'b0, 4'hF, 32'h0, 32'h0, r, e, lat, bh);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL load_latency got %0d want 4", lat); end
    n_cmp++; if (bh !== 0) begin n_bad++; $display("FAIL load_stall_ready bad cycles %0d want 0", bh); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL load_err got %b want 0", e); end
  endtask

  task automatic test_store_load();
    logic [31:0] r; bit e; int lat, bh;
    access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, r, e, lat, bh);
    n_cmp++; if (lat !== 4 || e !== 1'b0 || r !== 32'h0)
      begin n_bad++; $display("FAIL store_rsp lat %0d err %b rdata %h want 4 0 0", lat, e, r); end
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, r, e, lat, bh);
    n_cmp++; if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_back got %h want deadbeef", r); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL load_back_err got %b want 0", e); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] r; bit e; int lat, bh;
    access(0, 1'b1, 4'b0001, 32'h10, 32'h000000AA, r, e, lat, bh);
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, r, e, lat, bh);
    n_cmp++; if (r !== 32'hDEADBEAA) begin n_bad++; $display("FAIL be0001 got %h want deadbeaa", r); end
    access(0, 1'b1, 4'b0000, 32'h10, 32'h55555555, r, e, lat, bh);
    n_cmp++; if (lat !== 4 || bh !== 0) begin n_bad++; $display("FAIL be0000_rsp lat %0d badhs %0d want 4 0", lat, bh); end
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, r, e, lat, bh);
    n_cmp++; if (r !== 32'hDEADBEAA) begin n_bad++; $display("FAIL be0000_unchanged got %h want deadbeaa", r); end
  endtask

  task automatic test_faults();
    logic [31:0] r; bit e; int lat, bh;
    access(0, 1'b0, 4'hF, 32'h13, 32'h0, r, e, lat, bh);
    n_cmp++; if (e !== 1'b1 || r !== 32'h0) begin n_bad++; $display("FAIL misaligned err %b rdata %h want 1 0", e, r); end
    access(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, r, e, lat, bh);
    access(0, 1'b1, 4'hF, 32'h100, 32'h99999999, r, e, lat, bh);
    n_cmp++; if (e !== 1'b1 || lat !== 4) begin n_bad++; $display("FAIL out_of_range err %b lat %0d want 1 4", e, lat); end
    access(0, 1'b0, 4'hF, 32'h0, 32'h0, r, e, lat, bh);
    n_cmp++; if (r !== 32'hCAFEF00D || e !== 1'b0)
      begin n_bad++; $display("FAIL word0_after_fault got %h err %b want cafef00d 0", r, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; bit e; int lat, bh, pulses;
    access(0, 1'b1, 4'hF, 32'h20, 32'h11111111, r, e, lat, bh);
    pulses = 0;
    @(negedge clk);
    vld[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h20; wd[0] = 32'h12345678;
    @(negedge clk);            // first WAIT cycle
    rst[0] = 1'b1; vld[0] = 1'b0;
    #1; if (rv[0]) pulses++;
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL midreset_ready got %b want 1", rdy[0]); end
    for (int k = 0; k < 6; k++) begin
      if (rv[0]) pulses++;
      @(negedge clk); #1;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midreset_no_rsp pulses %0d want 0", pulses); end
    access(0, 1'b0, 4'hF, 32'h20, 32'h0, r, e, lat, bh);
    n_cmp++; if (r !== 32'h11111111) begin n_bad++; $display("FAIL midreset_no_write got %h want 11111111", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; bit e; int lat, bh;
    bit xr, xv;
    access(1, 1'b1, 4'hF, 32'h0, 32'hA0A00001, r, e, lat, bh);
    n_cmp++; if (lat !== 2 || bh !== 0) begin n_bad++; $display("FAIL lat0_store lat %0d badhs %0d want 2 0", lat, bh); end
    access(1, 1'b1, 4'hF, 32'h4, 32'hB0B00002, r, e, lat, bh);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      vld[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = (c <= 3) ? 32'h0 : 32'h4;
      #1;
      xr = (c == 1 || c == 4);
      xv = (c == 3 || c == 6);
      n_cmp++; if (rdy[1] !== xr) begin n_bad++; $display("FAIL b2b_ready cycle %0d got %b want %b", c, rdy[1], xr); end
      n_cmp++; if (rv[1] !== xv) begin n_bad++; $display("FAIL b2b_rsp_valid cycle %0d got %b want %b", c, rv[1], xv); end
      if (c == 3) begin
        n_cmp++; if (rd[1] !== 32'hA0A00001) begin n_bad++; $display("FAIL b2b_rdata1 got %h want a0a00001", rd[1]); end
      end
      if (c == 6) begin
        n_cmp++; if (rd[1] !== 32'hB0B00002) begin n_bad++; $display("FAIL b2b_rdata2 got %h want b0b00002", rd[1]); end
      end
    end
    @(negedge clk);
    vld[1] = 1'b0;
  endtask

  // Random traffic against a plain word-array model of the memory.
  task automatic test_random(input int s);
    logic [31:0] mem [64];
    logic [31:0] r, a, d, xr;
    logic [3:0]  b;
    bit e, w, xe;
    int lat, bh, kind;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      mem[i] = d;
      access(s, 1'b1, 4'hF, i * 4, d, r, e, lat, bh);
      n_cmp++; if (e !== 1'b0 || lat !== lat_of(s) + 2)
        begin n_bad++; $display("FAIL fill dut%0d word %0d err %b lat %0d", s, i, e, lat); end
    end
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (kind == 1) a = 32'h100 + 32'($urandom_range(0, 1 << 20) * 4);
      else                a = 32'($urandom_range(0, 63) * 4);
      w = 1'($urandom_range(0, 1));
      b = 4'($urandom_range(0, 15));
      d = $urandom;
      xe = (a % 4 != 0) || (a / 4 >= 64);
      xr = 32'h0;
      if (!xe && w) begin
        for (int i = 0; i < 4; i++) if (b[i]) mem[a / 4][8*i +: 8] = d[8*i +: 8];
      end
      if (!xe && !w) xr = mem[a / 4];
      access(s, w, b, a, d, r, e, lat, bh);
      n_cmp++; if (r !== xr || e !== xe)
        begin n_bad++; $display("FAIL rand dut%0d op %0d addr %h we %b rdata %h err %b want %h %b", s, t, a, w, r, e, xr, xe); end
      n_cmp++; if (lat !== lat_of(s) + 2 || bh !== 0)
        begin n_bad++; $display("FAIL rand_timing dut%0d op %0d lat %0d badhs %0d want %0d 0", s, t, lat, bh, lat_of(s) + 2); end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; vld[s] = 1'b0; we[s] = 1'b0; be[s] = 4'h0; addr[s] = 32'h0; wd[s] = 32'h0;
    end
    test_reset();
    test_load_timing();
    test_store_load();
    test_byte_enable();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
